// File: rtl/div_strobe_scheduler.sv
`default_nettype none
// ============================================================================
// div_strobe_scheduler : turns divider-counter bit rises into round-robin grants
// Revision 1.0
// ============================================================================
module div_strobe_scheduler #(
  parameter int DIV_WIDTH = 32,
  parameter int CH        = 4,
  parameter int TAP_W     = $clog2(DIV_WIDTH)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   cfg_we,
  input  logic [$clog2(CH)-1:0]  cfg_ch,
  input  logic                   cfg_en,
  input  logic [TAP_W-1:0]       cfg_tap,
  output logic                   div_ena,
  input  logic [DIV_WIDTH-1:0]   div_cnt,
  output logic [CH-1:0]          grant,
  output logic                   grant_valid,
  input  logic                   grant_ready,
  output logic [CH-1:0]          pending,
  output logic [CH-1:0]          ovf
);
  localparam int            CH_W   = $clog2(CH);
  localparam logic [CH_W:0] CH_NUM = (CH_W+1)'(CH);
  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    OFFER  = 1'b1;

  logic [CH-1:0]    en_q, en_d, prev_q, prev_d, pending_q, pending_d, ovf_q, ovf_d;
  logic [TAP_W-1:0] tap_q [CH];
  logic [TAP_W-1:0] tap_d [CH];
  logic             div_ena_q, div_ena_d;
  logic [0:0]       state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d, gidx_q, gidx_d;
  logic [CH-1:0]    grant_q, grant_d;
  logic             handshake;
  logic [CH-1:0]    avail;
  logic [2*CH-1:0]  rot;
  logic             found;
  logic [CH_W-1:0]  offs;
  logic [CH_W:0]    sum;

  assign handshake = (state_q == OFFER) && grant_ready;

  always_comb begin
    en_d      = en_q;
    prev_d    = prev_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    avail     = pending_q;
    for (int i = 0; i < CH; i++) begin
      tap_d[i] = tap_q[i];
      if (handshake && grant_q[i]) pending_d[i] = 1'b0;
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        // A write resamples the new tap so retargeting never fakes a rise.
        en_d[i]   = cfg_en;
        tap_d[i]  = cfg_tap;
        prev_d[i] = div_cnt[cfg_tap];
        ovf_d[i]  = 1'b0;
        if (!cfg_en && !((state_q == OFFER) && grant_q[i])) begin
          pending_d[i] = 1'b0;
          avail[i]     = 1'b0;
        end
      end else begin
        prev_d[i] = div_cnt[tap_q[i]];
        if (en_q[i] && div_cnt[tap_q[i]] && !prev_q[i]) begin
          if (pending_q[i] && !(handshake && grant_q[i])) ovf_d[i] = 1'b1;
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rot   = {avail, avail} >> ptr_q;
    found = 1'b0;
    offs  = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        offs  = CH_W'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, offs};
    if (sum >= CH_NUM) sum = sum - CH_NUM;

    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    div_ena_d = |en_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OFFER;
          gidx_d  = sum[CH_W-1:0];
          grant_d = {{(CH-1){1'b0}}, 1'b1} << sum[CH_W-1:0];
        end
      end
      default: begin
        if (grant_ready) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == CH_W'(CH - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q      <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      div_ena_q <= 1'b0;
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      for (int i = 0; i < CH; i++) tap_q[i] <= '0;
    end else begin
      en_q      <= en_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      div_ena_q <= div_ena_d;
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      for (int i = 0; i < CH; i++) tap_q[i] <= tap_d[i];
    end
  end

  assign div_ena     = div_ena_q;
  assign grant       = grant_q;
  assign grant_valid = (state_q == OFFER);
  assign pending     = pending_q;
  assign ovf         = ovf_q;

endmodule
`default_nettype wire
